matbi_stream_rr_arbiter: RTL and testbench
==========================================

Name: matbi_stream_rr_arbiter

Overview:
- Packet-level round-robin arbiter.
- Shares one valid/ready/data stream, e.g. the input of a matbi_sync_fifo command queue, among NUM_REQ requesters.
- Once a requester is granted, it holds the output until its beat with s_last handshakes. The grant then rotates.
- Output is registered: one-entry, fully pipelined, so downstream timing is decoupled.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- LOG2_NUM_REQ, 2, width of the requester id; equals clog2(NUM_REQ).
- DATA_WIDTH, 32, payload width per beat.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  NUM_REQ  per-requester valid.
- s_ready  out  NUM_REQ  per-requester ready.
- s_data  in  NUM_REQ*DATA_WIDTH  flattened payload; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_last  in  NUM_REQ  per-requester last-beat-of-packet flag.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.
- m_data  out  DATA_WIDTH  output payload.
- m_last  out  1  output last flag.
- m_id  out  LOG2_NUM_REQ  index of the requester that sourced the beat.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, grant=0, last_grant=NUM_REQ-1.
  - m_valid=0; m_data, m_last and m_id = 0.
  - s_ready=0 on all requesters.
- Output register:
  - out_ready = ~m_valid | m_ready.
  - When an input beat is accepted, {m_data, m_last, m_id} load on that edge and m_valid=1.
  - If m_ready handshakes with no new beat accepted, m_valid clears.
  - Latency from input handshake to m_valid is 1 cycle. Throughput is 1 beat/cycle within a packet.
  - m_* stay stable while m_valid && !m_ready.
- FSM IDLE:
  - All s_ready=0.
  - If any s_valid: grant = first index with s_valid, searching from last_grant+1 upward modulo NUM_REQ. Next state is BUSY.
  - If no s_valid, stay in IDLE.
- FSM BUSY:
  - s_ready[grant] = out_ready; every other s_ready = 0.
  - Beat handshake on requester grant when s_valid[grant] && s_ready[grant].
  - On a handshake with s_last[grant]=1: last_grant <= grant, next state is IDLE.
  - Each packet costs exactly one arbitration bubble cycle (the IDLE cycle).
- Requester rules:
  - A requester must not drop s_valid or change s_data/s_last before its handshake. Behaviour is undefined otherwise.
  - A requester dropping s_valid mid-packet keeps the grant; the arbiter waits indefinitely.
- Boundaries:
  - Single-beat packet (s_last=1 on the first beat): BUSY lasts 1 cycle.
  - Wrap: last_grant=NUM_REQ-1 searches from 0.
  - All requesters valid: grants follow strict rotation 0,1,2,3,0,...
  - Only the last_grant requester valid: it is re-granted.
  - m_ready low while BUSY: s_ready[grant] follows out_ready. At most one beat is held in the output register, with no loss.
  - Reset mid-packet: the packet is truncated and the held output beat is discarded. Upstream must also be reset.

Optional Feature:
- Macro MATBI_ARB_GRANT_CNT_EN.
- When defined:
  - Adds output grant_cnt, width NUM_REQ*16.
  - Holds one 16-bit counter per requester. Counter k increments on every IDLE->BUSY transition that grants k, and saturates at 16'hFFFF.
  - Counters clear on reset.
- When undefined: the port and the counters are absent. Function is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=1'b0, BUSY=1'b1.
  - Counter width constant GRANT_CNT_W=16.
- Sub-module matbi_rr_pick:
  - Combinational rotate-priority picker.
  - Inputs: req[NUM_REQ], last_grant.
  - Outputs: any_req, pick index.
  - Instanced once; unit-testable in isolation.

Test Plan:
- Reset: assert reset asynchronously between edges -> m_valid=0 and s_ready=0 immediately; after release, first grant goes to requester 0 when all are valid.
- Rotation: all four requesters valid, 1-beat packets, m_ready=1 -> m_id sequence 0,1,2,3,0,1; one output beat every 2 cycles.
- Burst lock: requester 2 sends a 5-beat packet (data 0xA0..0xA4, last on beat 5) while requester 1 is valid -> m_id=2 for 5 consecutive beats in order, then m_id=1.
- Backpressure: m_ready toggles 1,0,0,1 mid-packet -> no beat dropped or duplicated; m_data is held while m_ready=0.
- Wrap and solo: only requester 3 valid, 3 packets -> re-granted 3 times. Then requesters 0 and 3 valid -> 0 is granted next.
- With MATBI_ARB_GRANT_CNT_EN: 10 packets from requester 1 -> grant_cnt[31:16]=10, other counters 0; reset clears all counters.

Source files
------------

// File: rtl/matbi_stream_rr_arbiter_pkg.sv
// Shared definitions for the packet-level round-robin stream arbiter:
// FSM state encoding and the per-requester grant counter width.
package matbi_stream_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/matbi_rr_pick.sv
// Combinational rotate-priority picker: returns the first requester with
// req set, searching upward from last_grant+1 and wrapping modulo NUM_REQ.
// The last_grant requester itself has the lowest priority.
module matbi_rr_pick #(
  parameter int NUM_REQ      = 4,
  parameter int LOG2_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]      req,
  input  logic [LOG2_NUM_REQ-1:0] last_grant,
  output logic                    any_req,
  output logic [LOG2_NUM_REQ-1:0] pick
);

  logic                    found;
  logic [LOG2_NUM_REQ-1:0] idx;

  // Walk the requesters in rotated order and keep the first hit.
  always_comb begin
    any_req = |req;
    pick    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = LOG2_NUM_REQ'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matbi_stream_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one valid/ready/data stream
// among NUM_REQ requesters. A granted requester owns the output until its
// s_last beat handshakes; an IDLE cycle then re-arbitrates. The output is a
// one-entry, fully pipelined register stage.
// Optional macro MATBI_ARB_GRANT_CNT_EN adds grant_cnt: one saturating
// 16-bit counter per requester, bumped on every grant.
module matbi_stream_rr_arbiter
  import matbi_stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOG2_NUM_REQ = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              s_valid,
  output logic [NUM_REQ-1:0]              s_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_REQ-1:0]              s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
`ifdef MATBI_ARB_GRANT_CNT_EN
  output logic [NUM_REQ*GRANT_CNT_W-1:0]  grant_cnt,
`endif
  output logic [LOG2_NUM_REQ-1:0]         m_id
);

  arb_state_t              state_q, state_d;
  logic [LOG2_NUM_REQ-1:0] grant_q, grant_d;
  logic [LOG2_NUM_REQ-1:0] last_grant_q, last_grant_d;
  logic                    any_req;
  logic [LOG2_NUM_REQ-1:0] pick;
  logic                    out_ready;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   sel_data;

  matbi_rr_pick #(
    .NUM_REQ      (NUM_REQ),
    .LOG2_NUM_REQ (LOG2_NUM_REQ)
  ) u_pick (
    .req        (s_valid),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .pick       (pick)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign out_ready = ~m_valid | m_ready;

  // Payload mux for the currently granted requester.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q == LOG2_NUM_REQ'(k)) begin
        sel_data = s_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM state, grant and rotation pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LOG2_NUM_REQ'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state, grant selection and per-requester ready.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_ready      = '0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_ready[grant_q] = out_ready;
        accept           = s_valid[grant_q] & out_ready;
        if (accept && s_last[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-entry output register: load on accept, clear when drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
      m_last  <= s_last[grant_q];
      m_id    <= grant_q;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef MATBI_ARB_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] cnt_q [NUM_REQ];

  // Count IDLE->BUSY grants per requester, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (state_q == IDLE && any_req && cnt_q[pick] != '1) begin
      cnt_q[pick] <= cnt_q[pick] + GRANT_CNT_W'(1);
    end
  end

  // Flatten the counters onto the grant_cnt port.
  always_comb begin
    grant_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_cnt[k*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_matbi_stream_rr_arbiter.sv
// Directed testbench for matbi_stream_rr_arbiter: a vector table for the
// all-valid rotation plus hand-written multi-cycle sequences.
module tb_matbi_stream_rr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   s_valid, s_ready, s_last;
  logic [127:0] s_data;
  logic         m_valid, m_ready, m_last;
  logic [31:0]  m_data;
  logic [1:0]   m_id;
`ifdef MATBI_ARB_GRANT_CNT_EN
  logic [63:0]  grant_cnt;
`endif

  always #5 clk = ~clk;

  matbi_stream_rr_arbiter #(
    .NUM_REQ      (4),
    .LOG2_NUM_REQ (2),
    .DATA_WIDTH   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
`ifdef MATBI_ARB_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .m_id      (m_id)
  );

  logic        sv_r [4];
  logic [31:0] sd_r [4];
  logic        sl_r [4];

  always_comb begin
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    for (int k = 0; k < 4; k++) begin
      s_valid[k]          = sv_r[k];
      s_last[k]           = sl_r[k];
      s_data[k*32 +: 32]  = sd_r[k];
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t q[$];

  // Record every output beat that handshakes (sampled mid-cycle).
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) q.push_back({m_id, m_data, m_last});
  end

  typedef struct {
    logic [3:0]  sv;
    logic [3:0]  sl;
    logic        mr;
    logic [3:0]  exp_rdy;
    logic        exp_mv;
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl [13];
  logic        pat [12];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd       = 0;
  logic        hold_prev;
  logic [31:0] held_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut;
    reset   = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sv_r[k] = 1'b0;
      sl_r[k] = 1'b0;
    end
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    rd = q.size();
  endtask

  task automatic step;
    @(posedge clk); #2;
  endtask

  // Present an n-beat packet on requester k; called at posedge+2 phase.
  task automatic send_pkt(input int k, input int n, input logic [31:0] base);
    int   cyc;
    logic hs;
    for (int b = 0; b < n; b++) begin
      sv_r[k] = 1'b1;
      sd_r[k] = base + 32'(b);
      sl_r[k] = (b == n - 1);
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 60) begin
        @(negedge clk);
        hs = s_ready[k];
        @(posedge clk); #2;
        cyc++;
      end
      if (!hs) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: requester %0d beat %0d ready=0 after 60 cycles, required 1", k, b);
      end
    end
    sv_r[k] = 1'b0;
    sl_r[k] = 1'b0;
  endtask

  task automatic expect_beat(input string name, input logic [1:0] id,
                             input logic [31:0] d, input logic l);
    if (rd >= q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no beat observed, expected id=%0d data=%0h last=%0d", name, id, d, l);
    end else begin
      chk(name, 64'(q[rd]), 64'({id, d, l}));
      rd++;
    end
  endtask

  task automatic expect_no_more(input string name);
    chk(name, 64'(q.size() - rd), 64'd0);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 32'h0};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 32'h10};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 32'h0};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 32'h11};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b0, 2'd0, 32'h0};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 32'h12};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b0, 2'd0, 32'h0};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 32'h13};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 32'h0};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 32'h10};
    tbl[11] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 32'h0};
    tbl[12] = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 32'h11};
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    hold_prev = 1'b0;
    held_data = '0;
    for (int k = 0; k < 4; k++) begin
      sv_r[k] = 1'b0;
      sl_r[k] = 1'b0;
      sd_r[k] = 32'h0;
    end
    m_ready = 1'b1;
    reset   = 1'b1;

    // Reset state while reset is held.
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_fields", 64'({m_data, m_last, m_id}), 64'd0);
`ifdef MATBI_ARB_GRANT_CNT_EN
    chk("rst_grant_cnt", grant_cnt, 64'd0);
`endif

    // Rotation table: all valid, single-beat packets, m_ready high.
    reset_dut();
    for (int k = 0; k < 4; k++) sd_r[k] = 32'h10 + 32'(k);
    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < 4; k++) begin
        sv_r[k] = tbl[r].sv[k];
        sl_r[k] = tbl[r].sl[k];
      end
      m_ready = tbl[r].mr;
      @(negedge clk);
      chk($sformatf("rot_s_ready[%0d]", r), 64'(s_ready), 64'(tbl[r].exp_rdy));
      chk($sformatf("rot_m_valid[%0d]", r), 64'(m_valid), 64'(tbl[r].exp_mv));
      if (tbl[r].exp_mv)
        chk($sformatf("rot_id_data[%0d]", r), 64'({m_id, m_data}),
            64'({tbl[r].exp_id, tbl[r].exp_data}));
      step();
    end

    // Burst lock: requester 2 five-beat packet, requester 1 waiting.
    reset_dut();
    fork
      send_pkt(2, 5, 32'hA0);
      begin
        step();
        send_pkt(1, 1, 32'h55);
      end
    join
    repeat (3) step();
    for (int b = 0; b < 5; b++)
      expect_beat($sformatf("burst_beat%0d", b), 2'd2, 32'hA0 + 32'(b), b == 4);
    expect_beat("burst_after", 2'd1, 32'h55, 1'b1);
    expect_no_more("burst_extra");

    // Backpressure mid-packet: m_ready 1,0,0,1 while beats are flowing.
    reset_dut();
    hold_prev = 1'b0;
    fork
      send_pkt(0, 4, 32'hB0);
      begin
        for (int i = 0; i < 12; i++) begin
          m_ready = pat[i];
          @(negedge clk);
          if (hold_prev) chk("bp_hold", 64'({m_valid, m_data}), 64'({1'b1, held_data}));
          if (m_valid && !m_ready) begin
            chk("bp_s_ready_low", 64'(s_ready), 64'd0);
            held_data = m_data;
            hold_prev = 1'b1;
          end else begin
            hold_prev = 1'b0;
          end
          step();
        end
      end
    join
    m_ready = 1'b1;
    repeat (3) step();
    for (int b = 0; b < 4; b++)
      expect_beat($sformatf("bp_beat%0d", b), 2'd0, 32'hB0 + 32'(b), b == 3);
    expect_no_more("bp_extra");

    // Solo requester 3 is re-granted; then 0 wins over 3 after a wrap.
    reset_dut();
    send_pkt(3, 1, 32'hC0);
    send_pkt(3, 1, 32'hC1);
    send_pkt(3, 2, 32'hC2);
    fork
      send_pkt(0, 1, 32'hD0);
      send_pkt(3, 1, 32'hD3);
    join
    repeat (3) step();
    expect_beat("solo_p1", 2'd3, 32'hC0, 1'b1);
    expect_beat("solo_p2", 2'd3, 32'hC1, 1'b1);
    expect_beat("solo_p3a", 2'd3, 32'hC2, 1'b0);
    expect_beat("solo_p3b", 2'd3, 32'hC3, 1'b1);
    expect_beat("wrap_first", 2'd0, 32'hD0, 1'b1);
    expect_beat("wrap_second", 2'd3, 32'hD3, 1'b1);
    expect_no_more("wrap_extra");

    // Asynchronous reset mid-packet with a beat held in the output.
    reset_dut();
    m_ready = 1'b0;
    sv_r[1] = 1'b1;
    sd_r[1] = 32'h77;
    sl_r[1] = 1'b0;
    step();
    step();
    chk("arst_pre_m_valid", 64'(m_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_s_ready", 64'(s_ready), 64'd0);
    chk("arst_m_data", 64'(m_data), 64'd0);
    step();
    sv_r[1] = 1'b0;
    reset   = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sv_r[k] = 1'b1;
      sl_r[k] = 1'b1;
    end
    @(negedge clk);
    chk("arst_idle_ready", 64'(s_ready), 64'd0);
    step();
    @(negedge clk);
    chk("arst_first_grant", 64'(s_ready), 64'h1);
    step();

`ifdef MATBI_ARB_GRANT_CNT_EN
    // Grant counters: ten packets from requester 1, then reset.
    reset_dut();
    for (int p = 0; p < 10; p++) send_pkt(1, 1, 32'hE0 + 32'(p));
    repeat (3) step();
    chk("cnt_after_10", grant_cnt, 64'h0000_0000_000A_0000);
    reset = 1'b1;
    #1;
    chk("cnt_cleared", grant_cnt, 64'd0);
    step();
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
